// File: rtl/seek_arb_pkg.sv
// Shared widths, FSM encoding and result payload for the seek request arbiter.
package seek_arb_pkg;

  localparam int unsigned MAC_W     = 48;
  localparam int unsigned ID_W      = 4;
  localparam int unsigned OUTPORT_W = 3;
  localparam int unsigned FLAG_W    = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } seek_state_e;

  typedef struct packed {
    logic [OUTPORT_W-1:0] outport;
    logic [FLAG_W-1:0]    flag;
    logic [ID_W-1:0]      id;
  } seek_result_t;

  // Index width for n ports; a single port still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after the last grant wins.
module rr_arbiter
  import seek_arb_pkg::*;
#(
  parameter int unsigned P_N     = 2,
  parameter int unsigned P_IDX_W = idx_width(P_N)
) (
  input  logic [P_N-1:0]     i_req,
  input  logic [P_IDX_W-1:0] i_last_grant,
  output logic [P_N-1:0]     o_grant_c
);

  always_comb begin
    int unsigned idx;
    logic        found;
    o_grant_c = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 1; i <= P_N; i++) begin
      idx = (32'(i_last_grant) + i) % P_N;
      if (!found && i_req[P_IDX_W'(idx)]) begin
        o_grant_c[P_IDX_W'(idx)] = 1'b1;
        found                    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seek_req_arbiter.sv
// Shares one outport-lookup engine between P_PORT_NUM RX ports, one lookup in flight.
// Optional WAIT timeout is enabled by defining SEEK_TIMEOUT_EN.
module seek_req_arbiter
  import seek_arb_pkg::*;
#(
  parameter int unsigned P_PORT_NUM = 2,
  parameter int unsigned P_TIMEOUT  = 64
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [MAC_W*P_PORT_NUM-1:0] i_check_mac,
  input  logic [ID_W*P_PORT_NUM-1:0]  i_check_id,
  input  logic [P_PORT_NUM-1:0]       i_check_valid,
  output logic [MAC_W-1:0]            o_seek_mac,
  output logic [ID_W-1:0]             o_seek_id,
  output logic                        o_seek_valid,
  input  logic [OUTPORT_W-1:0]        i_seek_outport,
  input  logic [FLAG_W-1:0]           i_seek_flag,
  input  logic [ID_W-1:0]             i_seek_id,
  input  logic                        i_seek_result_valid,
  output logic [OUTPORT_W-1:0]        o_outport,
  output logic [FLAG_W-1:0]           o_seek_flag,
  output logic [ID_W-1:0]             o_result_id,
  output logic [P_PORT_NUM-1:0]       o_result_valid,
  output logic                        o_overrun,
  output logic                        o_id_err,
  output logic                        o_timeout_err
);

  localparam int unsigned IDX_W = idx_width(P_PORT_NUM);

  if (P_PORT_NUM < 1 || P_PORT_NUM > 8 || P_TIMEOUT < 1) begin : g_param_chk
    $error("seek_req_arbiter: illegal P_PORT_NUM or P_TIMEOUT");
  end

  seek_state_e                          state_q, state_d;
  logic [P_PORT_NUM-1:0]                pending_q, pending_d;
  logic [P_PORT_NUM-1:0][MAC_W-1:0]     mac_q, mac_d;
  logic [P_PORT_NUM-1:0][ID_W-1:0]      id_q, id_d;
  logic [IDX_W-1:0]                     last_grant_q, last_grant_d;
  logic [IDX_W-1:0]                     owner_q, owner_d;
  logic [ID_W-1:0]                      issued_id_q, issued_id_d;
  logic [MAC_W-1:0]                     seek_mac_q, seek_mac_d;
  logic [ID_W-1:0]                      seek_id_q, seek_id_d;
  logic                                 seek_valid_q, seek_valid_d;
  seek_result_t                         result_q, result_d;
  logic [P_PORT_NUM-1:0]                result_valid_q, result_valid_d;
  logic                                 overrun_q, overrun_d;
  logic                                 id_err_q, id_err_d;

  logic [P_PORT_NUM-1:0]                rr_grant_c;
  logic [IDX_W-1:0]                     grant_idx_c;
  logic [P_PORT_NUM-1:0]                grant_clear_c;
  logic                                 id_match_c;

`ifdef SEEK_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(P_TIMEOUT + 1);
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic                                 timeout_err_q, timeout_err_d;
`endif

  rr_arbiter #(
    .P_N     (P_PORT_NUM),
    .P_IDX_W (IDX_W)
  ) u_rr (
    .i_req        (pending_q),
    .i_last_grant (last_grant_q),
    .o_grant_c    (rr_grant_c)
  );

  // One-hot grant to index.
  always_comb begin
    grant_idx_c = '0;
    for (int unsigned i = 0; i < P_PORT_NUM; i++) begin
      if (rr_grant_c[i]) grant_idx_c = IDX_W'(i);
    end
  end

  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    mac_d          = mac_q;
    id_d           = id_q;
    last_grant_d   = last_grant_q;
    owner_d        = owner_q;
    issued_id_d    = issued_id_q;
    seek_mac_d     = seek_mac_q;
    seek_id_d      = seek_id_q;
    seek_valid_d   = 1'b0;
    result_d       = result_q;
    result_valid_d = '0;
    overrun_d      = overrun_q;
    id_err_d       = 1'b0;
    grant_clear_c  = '0;
    id_match_c     = 1'b0;
`ifdef SEEK_TIMEOUT_EN
    cnt_d          = cnt_q;
    timeout_err_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          grant_clear_c = rr_grant_c;
          seek_mac_d    = mac_q[grant_idx_c];
          seek_id_d     = id_q[grant_idx_c];
          seek_valid_d  = 1'b1;
          last_grant_d  = grant_idx_c;
          owner_d       = grant_idx_c;
          issued_id_d   = id_q[grant_idx_c];
          state_d       = ST_WAIT;
`ifdef SEEK_TIMEOUT_EN
          cnt_d         = '0;
`endif
        end
      end
      ST_WAIT: begin
        id_match_c = i_seek_result_valid && (i_seek_id == issued_id_q);
        if (id_match_c) begin
          result_d                = '{outport: i_seek_outport, flag: i_seek_flag, id: i_seek_id};
          result_valid_d[owner_q] = 1'b1;
          state_d                 = ST_IDLE;
        end else if (i_seek_result_valid) begin
          id_err_d = 1'b1;
        end
`ifdef SEEK_TIMEOUT_EN
        // A matching result in the last allowed cycle still completes normally.
        if (!id_match_c) begin
          if (cnt_q == CNT_W'(P_TIMEOUT - 1)) begin
            timeout_err_d = 1'b1;
            state_d       = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // A fresh capture overrides a same-cycle grant clear on that port.
    pending_d = (pending_q & ~grant_clear_c) | i_check_valid;
    overrun_d = overrun_q | (|(i_check_valid & pending_q));
    for (int unsigned k = 0; k < P_PORT_NUM; k++) begin
      if (i_check_valid[k]) begin
        mac_d[k] = i_check_mac[k*MAC_W +: MAC_W];
        id_d[k]  = i_check_id[k*ID_W +: ID_W];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= ST_IDLE;
      pending_q      <= '0;
      mac_q          <= '0;
      id_q           <= '0;
      last_grant_q   <= IDX_W'(P_PORT_NUM - 1);
      owner_q        <= '0;
      issued_id_q    <= '0;
      seek_mac_q     <= '0;
      seek_id_q      <= '0;
      seek_valid_q   <= 1'b0;
      result_q       <= '0;
      result_valid_q <= '0;
      overrun_q      <= 1'b0;
      id_err_q       <= 1'b0;
`ifdef SEEK_TIMEOUT_EN
      cnt_q          <= '0;
      timeout_err_q  <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      mac_q          <= mac_d;
      id_q           <= id_d;
      last_grant_q   <= last_grant_d;
      owner_q        <= owner_d;
      issued_id_q    <= issued_id_d;
      seek_mac_q     <= seek_mac_d;
      seek_id_q      <= seek_id_d;
      seek_valid_q   <= seek_valid_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overrun_q      <= overrun_d;
      id_err_q       <= id_err_d;
`ifdef SEEK_TIMEOUT_EN
      cnt_q          <= cnt_d;
      timeout_err_q  <= timeout_err_d;
`endif
    end
  end

  assign o_seek_mac     = seek_mac_q;
  assign o_seek_id      = seek_id_q;
  assign o_seek_valid   = seek_valid_q;
  assign o_outport      = result_q.outport;
  assign o_seek_flag    = result_q.flag;
  assign o_result_id    = result_q.id;
  assign o_result_valid = result_valid_q;
  assign o_overrun      = overrun_q;
  assign o_id_err       = id_err_q;
`ifdef SEEK_TIMEOUT_EN
  assign o_timeout_err  = timeout_err_q;
`else
  assign o_timeout_err  = 1'b0;
`endif

endmodule

// File: doc/seek_req_arbiter.md
SEEK_REQ_ARBITER -- requirements
Module: seek_req_arbiter

Interface
REQ-001 SHALL have parameter P_PORT_NUM, default 2 (legal 1..8): number of RX ports sharing one outport-lookup engine.
REQ-002 SHALL have parameter P_TIMEOUT, default 64: WAIT-state cycle limit, used only when SEEK_TIMEOUT_EN is defined.
REQ-003 Ports (name, direction, width, meaning):
- i_clk  in  1  single clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_check_mac  in  48*P_PORT_NUM  per-port destination MAC; port k occupies bits [48k+47:48k].
- i_check_id  in  4*P_PORT_NUM  per-port requester id.
- i_check_valid  in  P_PORT_NUM  per-port single-cycle request pulse.
- o_seek_mac  out  48  MAC presented to the lookup engine.
- o_seek_id  out  4  id presented to the lookup engine.
- o_seek_valid  out  1  single-cycle lookup request pulse.
- i_seek_outport  in  3  engine result: output port.
- i_seek_flag  in  2  engine result: seek flag.
- i_seek_id  in  4  engine result: echoed id.
- i_seek_result_valid  in  1  engine result pulse.
- o_outport  out  3  result broadcast to all ports.
- o_seek_flag  out  2  result broadcast to all ports.
- o_result_id  out  4  result broadcast to all ports.
- o_result_valid  out  P_PORT_NUM  one-hot pulse to the port owning the result.
- o_overrun  out  1  sticky: a request arrived on a port that was already pending.
- o_id_err  out  1  pulse: result id did not match the issued id.
- o_timeout_err  out  1  pulse: WAIT exceeded P_TIMEOUT.

Function
REQ-004 SHALL capture each i_check_valid[k] pulse into a one-deep per-port holding register (pending[k], mac, id) one cycle after the pulse.
REQ-005 Capture on a port already pending SHALL overwrite mac/id and set o_overrun; o_overrun clears only on reset.
REQ-006 FSM states SHALL be IDLE and WAIT; exactly one lookup outstanding at any time.
REQ-007 IDLE with any pending bit set: grant round-robin starting from last_grant+1 (mod P_PORT_NUM); next cycle o_seek_valid=1 with the granted mac/id, pending[grant] cleared, last_grant updated, state -> WAIT.
REQ-008 Capture and grant-clear on the same port in the same cycle: capture wins; pending stays 1 with the new mac/id.
REQ-009 Request pulse at cycle t with FSM idle and no other pending: o_seek_valid at t+2.
REQ-010 WAIT with i_seek_result_valid and i_seek_id==issued id: next cycle o_result_valid[granted]=1 with o_outport/o_seek_flag/o_result_id registered from the result; state -> IDLE; the next grant is issued no earlier than the following cycle.
REQ-011 WAIT with i_seek_result_valid and an id mismatch: result dropped, o_id_err pulses one cycle, state remains WAIT.
REQ-012 i_seek_result_valid received in IDLE SHALL be ignored, with no error.
REQ-013 o_result_valid, o_seek_valid, o_id_err and o_timeout_err SHALL each be high for exactly one cycle per event.

Reset
REQ-014 Reset SHALL clear all pending bits, holding registers, all outputs and state (IDLE), and set last_grant=P_PORT_NUM-1 so port 0 is served first; reset mid-WAIT abandons the outstanding lookup silently.

Configuration
REQ-015 With SEEK_TIMEOUT_EN defined: WAIT cycle counter; when it reaches P_TIMEOUT, o_timeout_err pulses, the request is dropped with no o_result_valid, and state -> IDLE. Counter clears on WAIT entry.
REQ-016 Without SEEK_TIMEOUT_EN: no counter; WAIT persists until a matching result arrives; o_timeout_err is tied 0.

Structure
REQ-017 Shared package seek_arb_pkg SHALL hold the MAC/ID/OUTPORT/FLAG width constants and the FSM state encoding.
REQ-018 Round-robin selection SHALL be a sub-module rr_arbiter (request vector plus last grant -> one-hot grant, combinational).

Verification
REQ-019 Port 0 request with mac 48'h8DBC5C4A0301, id 1, at cycle 10 -> o_seek_valid at cycle 12 with that mac/id; result outport 3, id 1 at cycle 15 -> o_result_valid=2'b01 at cycle 16, o_outport=3.
REQ-020 Ports 0 and 1 request in the same cycle -> port 0 served first, port 1 issued after port 0's result; a repeat of both -> port 0 again after port 1 (alternation holds).
REQ-021 Port 1 pulses twice while blocked in WAIT -> o_overrun=1; only the second mac is issued.
REQ-022 Result with id 5 while id 1 is outstanding -> o_id_err pulse, no o_result_valid, still WAIT; a later id-1 result completes normally.
REQ-023 SEEK_TIMEOUT_EN, P_TIMEOUT=64, no result -> o_timeout_err 64 cycles after WAIT entry; a pending port-1 request then issues.
REQ-024 i_rst asserted mid-WAIT with port 1 pending -> all outputs 0; after release the stale result is ignored and nothing issues until a new request arrives.
